// File: rtl/cdc_bus_synchronizer.sv
// ----------------------------------------------------------------------------
// cdc_bus_synchronizer
//
// Brings an N-bit bus that is asynchronous to clk_in into the clk_in domain.
// Every bit goes through its own STAGES-deep flop chain. The result is then
// qualified: a new bus value is only passed to data_out after it has been seen
// unchanged on the synchronizer output for STABLE_CYCLES consecutive cycles.
// This hides glitches and skewed multi-bit transitions from downstream logic.
//
// Ports
//   clk_in      sole clock, all flops on rising edge
//   rst_in      asynchronous active-low reset
//   data_in     [N] bus, asynchronous to clk_in
//   hold_in     synchronous freeze of data_out (qualification keeps running)
//   sync_out    [N] last synchronizer stage, unfiltered
//   rise_out    [N] per-bit 0->1 event on sync_out (one cycle)
//   fall_out    [N] per-bit 1->0 event on sync_out (one cycle)
//   data_out    [N] filtered, stability-qualified bus value
//   data_valid  one-cycle pulse in the cycle data_out shows a new value
//   busy        sync_out differs from data_out (combinational)
// ----------------------------------------------------------------------------
module cdc_bus_synchronizer #(
    parameter int N             = 8,
    parameter int STAGES        = 2,
    parameter int STABLE_CYCLES = 3
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic [N-1:0] data_in,
    input  logic         hold_in,
    output logic [N-1:0] sync_out,
    output logic [N-1:0] rise_out,
    output logic [N-1:0] fall_out,
    output logic [N-1:0] data_out,
    output logic         data_valid,
    output logic         busy
);

    generate
        if (N < 1) begin : g_bad_width
            $error("cdc_bus_synchronizer: N must be >= 1");
        end
        if (STAGES < 2) begin : g_bad_stages
            $error("cdc_bus_synchronizer: STAGES must be >= 2");
        end
        if (STABLE_CYCLES < 1) begin : g_bad_stable
            $error("cdc_bus_synchronizer: STABLE_CYCLES must be >= 1");
        end
    endgenerate

    localparam int               CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    // ------------------------------------------------------------------
    // Synchronizer chain, one flop column per stage
    // ------------------------------------------------------------------
    logic [N-1:0] sync_ff [STAGES];

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_ff[i] <= '0;
            end
        end else begin
            sync_ff[0] <= data_in;
            for (int i = 1; i < STAGES; i++) begin
                sync_ff[i] <= sync_ff[i-1];
            end
        end
    end

    assign sync_out = sync_ff[STAGES-1];

    // ------------------------------------------------------------------
    // Edge detection against the previous synchronized sample
    // ------------------------------------------------------------------
    logic [N-1:0] sync_prev;

    assign rise_out = sync_out & ~sync_prev;
    assign fall_out = ~sync_out & sync_prev;

    // ------------------------------------------------------------------
    // Stability qualification
    //
    // stab_cnt_next is the number of consecutive cycles, including the
    // current one, that sync_out has shown its present value. It restarts
    // at 1 on any bit difference from the previous sample and saturates at
    // STABLE_CYCLES. When it reaches STABLE_CYCLES in the current cycle the
    // value is considered settled and may be committed on this edge, so
    // data_out shows it STABLE_CYCLES cycles after sync_out first did.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] stab_cnt;
    logic [CNT_W-1:0] stab_cnt_next;
    logic             qualified;
    logic             update;

    always_comb begin
        stab_cnt_next = stab_cnt;
        if (sync_out != sync_prev) begin
            stab_cnt_next = CNT_W'(1);
        end else if (stab_cnt != CNT_MAX) begin
            stab_cnt_next = stab_cnt + CNT_W'(1);
        end
    end

    assign qualified = (stab_cnt_next == CNT_MAX);

    // Comparing against data_out suppresses both no-change updates and any
    // repeat pulse while the counter sits saturated. Holding only gates the
    // commit; the counter keeps running, so a settled value is taken on the
    // first edge after hold_in drops.
    assign update = qualified && (sync_out != data_out) && !hold_in;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sync_prev  <= '0;
            stab_cnt   <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            sync_prev  <= sync_out;
            stab_cnt   <= stab_cnt_next;
            data_valid <= update;
            if (update) begin
                data_out <= sync_out;
            end
        end
    end

    assign busy = (sync_out != data_out);

    // ------------------------------------------------------------------
    // Embedded sanity properties
    // ------------------------------------------------------------------
    // A committed value is always the sample that was just qualified.
    a_valid_is_prev_sample : assert property (@(posedge clk_in) disable iff (!rst_in)
        data_valid |-> (data_out == sync_prev));

    // Nothing is committed on an edge where hold_in was high.
    a_no_commit_in_hold : assert property (@(posedge clk_in) disable iff (!rst_in)
        data_valid |-> !$past(hold_in));

endmodule

// File: tb/tb_cdc_bus_synchronizer.sv
module tb_cdc_bus_synchronizer;

    localparam int STAGES_A = 2;
    localparam int SC_A     = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] a_din;
    logic       a_hold;
    logic [7:0] a_sync, a_rise, a_fall, a_dout;
    logic       a_valid, a_busy;

    logic b_din, b_hold;
    logic b_sync, b_rise, b_fall, b_dout, b_valid, b_busy;

    cdc_bus_synchronizer #(.N(8), .STAGES(STAGES_A), .STABLE_CYCLES(SC_A)) dut_a (
        .clk_in(clk), .rst_in(rst_n), .data_in(a_din), .hold_in(a_hold),
        .sync_out(a_sync), .rise_out(a_rise), .fall_out(a_fall),
        .data_out(a_dout), .data_valid(a_valid), .busy(a_busy)
    );

    cdc_bus_synchronizer #(.N(1), .STAGES(3), .STABLE_CYCLES(1)) dut_b (
        .clk_in(clk), .rst_in(rst_n), .data_in(b_din), .hold_in(b_hold),
        .sync_out(b_sync), .rise_out(b_rise), .fall_out(b_fall),
        .data_out(b_dout), .data_valid(b_valid), .busy(b_busy)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [33:0] pack_a();
        return {a_sync, a_rise, a_fall, a_dout, a_valid, a_busy};
    endfunction

    function automatic logic [5:0] pack_b();
        return {b_sync, b_rise, b_fall, b_dout, b_valid, b_busy};
    endfunction

    // ------------------------------------------------------------------
    // Reference model: history of sampled inputs and synchronized values.
    // sync after edge k is data_in sampled STAGES-1 edges earlier; data_out
    // takes value V on edge k when the last SC_A cycle values were all V,
    // V differs from data_out and hold was low at that edge.
    // ------------------------------------------------------------------
    logic [7:0] m_din_q[$];
    logic [7:0] m_sync_q[$];
    logic [7:0] m_dout;
    logic       m_valid;
    logic       b_q[$];
    bit         model_on = 0;

    task automatic model_reset();
        m_din_q = {};
        m_sync_q = {};
        b_q = {};
        for (int i = 0; i < 5; i++) begin
            m_din_q.push_back(8'h00);
            m_sync_q.push_back(8'h00);
            b_q.push_back(1'b0);
        end
        m_dout = 8'h00;
        m_valid = 1'b0;
    endtask

    task automatic model_edge(input logic [7:0] din, input logic hold);
        logic [7:0] v;
        bit stable;
        v = m_sync_q[m_sync_q.size()-1];
        stable = 1;
        for (int i = 0; i < SC_A; i++) begin
            if (m_sync_q[m_sync_q.size()-1-i] != v) stable = 0;
        end
        m_valid = stable && (v != m_dout) && !hold;
        if (m_valid) m_dout = v;
        m_din_q.push_back(din);
        m_sync_q.push_back(m_din_q[m_din_q.size()-STAGES_A]);
        if (m_din_q.size() > 32) void'(m_din_q.pop_front());
        if (m_sync_q.size() > 32) void'(m_sync_q.pop_front());
    endtask

    function automatic logic [33:0] model_a();
        logic [7:0] s, p;
        s = m_sync_q[m_sync_q.size()-1];
        p = m_sync_q[m_sync_q.size()-2];
        return {s, s & ~p, ~s & p, m_dout, m_valid, s != m_dout};
    endfunction

    // N=1, STAGES=3, STABLE_CYCLES=1: sync is the input two edges back,
    // data_out is the sync value one edge later.
    function automatic logic [5:0] model_b();
        logic s, p, d, dp;
        s  = b_q[b_q.size()-3];
        p  = b_q[b_q.size()-4];
        d  = b_q[b_q.size()-4];
        dp = b_q[b_q.size()-5];
        return {s, s & ~p, ~s & p, d, d != dp, s != d};
    endfunction

    task automatic step();
        if (model_on) begin
            model_edge(a_din, a_hold);
            b_q.push_back(b_din);
            if (b_q.size() > 32) void'(b_q.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic [7:0] din;
        logic       hold;
        logic [7:0] sync, rise, fall, dout;
        logic       valid, busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [7:0] din, input logic [7:0] sync,
                                input logic [7:0] rise, input logic [7:0] fall,
                                input logic [7:0] dout, input logic valid, input logic busy);
        vec_t v;
        v.din = din; v.hold = 1'b0; v.sync = sync; v.rise = rise; v.fall = fall;
        v.dout = dout; v.valid = valid; v.busy = busy;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int vcount;
        int r;
        logic [7:0] exp_sync, exp_dout;
        logic exp_valid;

        // power-up through A5, glitch to FF, settle to 00, skewed 00->0F
        vecs.push_back(mk(8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0));
        vecs.push_back(mk(8'hA5, 8'hA5, 8'hA5, 8'h00, 8'h00, 0, 1));
        vecs.push_back(mk(8'hA5, 8'hA5, 8'h00, 8'h00, 8'h00, 0, 1));
        vecs.push_back(mk(8'hA5, 8'hA5, 8'h00, 8'h00, 8'h00, 0, 1));
        vecs.push_back(mk(8'hA5, 8'hA5, 8'h00, 8'h00, 8'hA5, 1, 0));
        vecs.push_back(mk(8'hA5, 8'hA5, 8'h00, 8'h00, 8'hA5, 0, 0));
        vecs.push_back(mk(8'hFF, 8'hA5, 8'h00, 8'h00, 8'hA5, 0, 0));
        vecs.push_back(mk(8'hA5, 8'hFF, 8'h5A, 8'h00, 8'hA5, 0, 1));
        vecs.push_back(mk(8'hA5, 8'hA5, 8'h00, 8'h5A, 8'hA5, 0, 0));
        vecs.push_back(mk(8'hA5, 8'hA5, 8'h00, 8'h00, 8'hA5, 0, 0));
        vecs.push_back(mk(8'hA5, 8'hA5, 8'h00, 8'h00, 8'hA5, 0, 0));
        vecs.push_back(mk(8'hA5, 8'hA5, 8'h00, 8'h00, 8'hA5, 0, 0));
        vecs.push_back(mk(8'h00, 8'hA5, 8'h00, 8'h00, 8'hA5, 0, 0));
        vecs.push_back(mk(8'h00, 8'h00, 8'h00, 8'hA5, 8'hA5, 0, 1));
        vecs.push_back(mk(8'h00, 8'h00, 8'h00, 8'h00, 8'hA5, 0, 1));
        vecs.push_back(mk(8'h00, 8'h00, 8'h00, 8'h00, 8'hA5, 0, 1));
        vecs.push_back(mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0));
        vecs.push_back(mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0));
        vecs.push_back(mk(8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0));
        vecs.push_back(mk(8'h0F, 8'h03, 8'h03, 8'h00, 8'h00, 0, 1));
        vecs.push_back(mk(8'h0F, 8'h0F, 8'h0C, 8'h00, 8'h00, 0, 1));
        vecs.push_back(mk(8'h0F, 8'h0F, 8'h00, 8'h00, 8'h00, 0, 1));
        vecs.push_back(mk(8'h0F, 8'h0F, 8'h00, 8'h00, 8'h00, 0, 1));
        vecs.push_back(mk(8'h0F, 8'h0F, 8'h00, 8'h00, 8'h0F, 1, 0));
        vecs.push_back(mk(8'h0F, 8'h0F, 8'h00, 8'h00, 8'h0F, 0, 0));

        rst_n = 1'b0; a_din = 8'h00; a_hold = 1'b0; b_din = 1'b0; b_hold = 1'b0;
        #1;
        check("reset_a", 64'(pack_a()), 64'h0);
        check("reset_b", 64'(pack_b()), 64'h0);
        repeat (2) @(posedge clk);
        #3;
        a_din = 8'hA5;
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            a_din  = vecs[i].din;
            a_hold = vecs[i].hold;
            step();
            check($sformatf("vec[%0d]", i), 64'(pack_a()),
                  64'({vecs[i].sync, vecs[i].rise, vecs[i].fall, vecs[i].dout,
                       vecs[i].valid, vecs[i].busy}));
        end

        // hold while 3C settles, then release
        a_hold = 1'b1;
        a_din  = 8'h3C;
        for (int k = 0; k < 10; k++) begin
            step();
            check($sformatf("hold_dout[%0d]", k), 64'({a_dout, a_valid}), 64'({8'h0F, 1'b0}));
        end
        check("hold_busy", 64'({a_sync, a_busy}), 64'({8'h3C, 1'b1}));
        a_hold = 1'b0;
        step();
        check("hold_release", 64'({a_dout, a_valid}), 64'({8'h3C, 1'b1}));
        step();
        check("hold_after", 64'({a_dout, a_valid, a_busy}), 64'({8'h3C, 1'b0, 1'b0}));

        // reset two cycles into qualification of 77
        a_din = 8'h77;
        repeat (3) step();
        check("pre_reset", 64'({a_sync, a_dout, a_busy}), 64'({8'h77, 8'h3C, 1'b1}));
        rst_n = 1'b0;
        #1;
        check("mid_reset_a", 64'(pack_a()), 64'h0);
        check("mid_reset_b", 64'(pack_b()), 64'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("held_reset_a", 64'(pack_a()), 64'h0);
        #2;
        rst_n = 1'b1;
        vcount = 0;
        for (int k = 1; k <= 8; k++) begin
            step();
            exp_sync  = (k >= 2) ? 8'h77 : 8'h00;
            exp_dout  = (k >= 5) ? 8'h77 : 8'h00;
            exp_valid = (k == 5);
            if (a_valid) vcount++;
            check($sformatf("post_reset[%0d]", k), 64'({a_sync, a_dout, a_valid}),
                  64'({exp_sync, exp_dout, exp_valid}));
        end
        check("post_reset_pulses", 64'(vcount), 64'd1);

        // randomized phase against the reference model, both instances
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        a_din = 8'h00; a_hold = 1'b0; b_din = 1'b0;
        #1;
        model_reset();
        check("rand_reset_a", 64'(pack_a()), 64'(model_a()));
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        model_on = 1;
        for (int c = 0; c < 500; c++) begin
            if (c < 6) b_din = 1'b1;
            else if ($urandom_range(0, 2) == 0) b_din = ~b_din;
            r = $urandom_range(0, 9);
            if (r < 2) a_din = 8'($urandom);
            else if (r == 2) a_din = a_din ^ (8'd1 << $urandom_range(0, 7));
            if ($urandom_range(0, 11) == 0) a_hold = ~a_hold;
            step();
            check($sformatf("rand_a[%0d]", c), 64'(pack_a()), 64'(model_a()));
            check($sformatf("rand_b[%0d]", c), 64'(pack_b()), 64'(model_b()));
            if (c == 2) check("b_latency_edge3", 64'({b_dout, b_valid}), 64'({1'b0, 1'b0}));
            if (c == 3) check("b_latency_edge4", 64'({b_dout, b_valid}), 64'({1'b1, 1'b1}));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cdc_bus_synchronizer.md
CDC_BUS_SYNCHRONIZER -- requirements
Module: cdc_bus_synchronizer

Interface
REQ-001 The block SHALL have parameter N, default 8: width of data bus (N >= 1).
REQ-002 The block SHALL have parameter STAGES, default 2: synchronizer flops per bit (STAGES >= 2).
REQ-003 The block SHALL have parameter STABLE_CYCLES, default 3: consecutive identical synchronized samples required before data_out updates (>= 1).
REQ-004 The block SHALL reject STAGES < 2 or STABLE_CYCLES < 1 at elaboration.
REQ-005 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clk_in  input  1  sole clock; all flops on rising edge.
- rst_in  input  1  asynchronous, active-low reset.
- data_in  input  N  bus asynchronous to clk_in.
- hold_in  input  1  synchronous; 1 freezes data_out.
- sync_out  output  N  last synchronizer stage, unfiltered.
- rise_out  output  N  per-bit 0->1 event on sync_out.
- fall_out  output  N  per-bit 1->0 event on sync_out.
- data_out  output  N  filtered, stability-qualified bus value.
- data_valid  output  1  one-cycle pulse when data_out takes a new value.
- busy  output  1  sync_out differs from data_out.

Function
REQ-006 Each bit of data_in SHALL pass through a STAGES-deep flop chain; sync_out SHALL be the last stage, with latency STAGES rising edges from a stable data_in change.
REQ-007 The block SHALL register sync_prev = sync_out delayed one cycle.
REQ-008 rise_out SHALL equal sync_out & ~sync_prev, and fall_out SHALL equal ~sync_out & sync_prev, each high for exactly the first cycle sync_out shows the new bit value.
REQ-009 A stability counter SHALL count consecutive cycles in which sync_out equals sync_prev, restart on any bit difference, and saturate at STABLE_CYCLES without wrapping.
REQ-010 Let T0 be the first cycle sync_out shows value V. If sync_out holds V for cycles T0..T0+STABLE_CYCLES-1, V differs from data_out, and hold_in is 0, then data_out SHALL equal V and data_valid SHALL be 1 in cycle T0+STABLE_CYCLES.
REQ-011 With STABLE_CYCLES = 1, data_out SHALL update one cycle after sync_out changes.
REQ-012 If sync_out changes before qualification completes (glitch or skewed multi-bit transition), data_out SHALL be unchanged, data_valid SHALL stay 0, and qualification SHALL restart on the new value.
REQ-013 If the qualified value equals the current data_out, the block SHALL produce neither an update nor a data_valid pulse.
REQ-014 data_valid SHALL pulse once per update, never on consecutive cycles for the same value, and SHALL not re-pulse while the counter is saturated.
REQ-015 While hold_in = 1, data_out SHALL NOT update and data_valid SHALL stay 0; the synchronizer, sync_out, rise_out, fall_out and the counter SHALL keep operating.
REQ-016 On the first edge after hold_in falls, if the counter is saturated and sync_out differs from data_out, data_out SHALL update and data_valid SHALL pulse in the following cycle.
REQ-017 busy SHALL be combinational (sync_out != data_out).

Reset
REQ-018 rst_in low SHALL immediately and asynchronously clear the chain flops, sync_prev, the counter, data_out and data_valid to 0.
REQ-019 During reset, sync_out, rise_out, fall_out, data_out, data_valid and busy SHALL all be 0.
REQ-020 Reset asserted mid-qualification SHALL discard the pending value, and no data_valid SHALL follow from it.
REQ-021 After rst_in rises, operation SHALL resume on the next rising clk_in edge with the chain refilling from 0.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- Defaults; release reset with data_in = 0xA5 held -> sync_out = 0xA5 at edge 2; rise_out = 0xA5 for 1 cycle; data_out = 0xA5 and data_valid = 1 at edge 5; busy 1 for edges 2..4.
- data_out = 0xA5; data_in pulses to 0xFF for 1 cycle -> sync_out 0xFF for 1 cycle; rise_out = 0x5A, then fall_out = 0x5A; data_out stays 0xA5; no data_valid.
- Skewed change 0x00 -> 0x0F, with bits 0-1 one cycle ahead of bits 2-3 -> no intermediate 0x03 on data_out; single data_valid with data_out = 0x0F.
- hold_in = 1 while 0x3C settles for 10 cycles -> data_out unchanged, busy = 1; hold_in falls -> data_out = 0x3C with one data_valid one cycle later.
- rst_in low two cycles into 0x77 qualification -> all outputs 0 immediately; after release with data_in = 0x77 -> full STAGES + STABLE_CYCLES latency, one data_valid.
- N = 1, STAGES = 3, STABLE_CYCLES = 1 -> data_out follows data_in 4 edges later; each toggle gives one data_valid.
